// File: rtl/led_mode_mux.sv
// LED mode selector: debounces mode_select, blanks the LEDs after each accepted change,
// then drives the selected driver bus active-low. Define LED_MODE_MUX_MASK_EN to add led_mask.
module led_mode_mux #(
  parameter int LED_W      = 8,
  parameter int NUM_MODES  = 4,
  parameter int MODE_W     = 4,
  parameter int STABLE_CYC = 4,
  parameter int BLANK_CYC  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_MODES*LED_W-1:0] drivers_signal,
  input  logic [MODE_W-1:0]          mode_select,
`ifdef LED_MODE_MUX_MASK_EN
  input  logic [LED_W-1:0]           led_mask,
`endif
  output logic [LED_W-1:0]           led_n,
  output logic [MODE_W-1:0]          mode_active,
  output logic                       busy,
  output logic                       mode_changed
);

  localparam int SW = (STABLE_CYC < 1) ? 1 : $clog2(STABLE_CYC + 1);
  localparam int BW = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);

  typedef enum logic [1:0] {RUN, QUAL, BLANK} state_t;

  state_t                         state, state_nxt;
  logic [MODE_W-1:0]              cand, cand_nxt, mode_nxt;
  logic [SW-1:0]                  stab_cnt, stab_nxt;
  logic [BW-1:0]                  blank_cnt, blank_nxt;
  logic                           accept;
  logic [NUM_MODES-1:0][LED_W-1:0] drv;
  logic [LED_W-1:0]               slice, led_nxt;
  logic                           in_range;

  assign drv = drivers_signal;

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    stab_nxt  = stab_cnt;
    blank_nxt = blank_cnt;
    mode_nxt  = mode_active;
    accept    = 1'b0;
    case (state)
      RUN: begin
        if (mode_select != mode_active) begin
          cand_nxt = mode_select;
          stab_nxt = SW'(1);
          if (STABLE_CYC <= 1) accept = 1'b1;
          else                 state_nxt = QUAL;
        end
      end
      QUAL: begin
        if (mode_select == cand) begin
          stab_nxt = stab_cnt + SW'(1);
          if (stab_cnt == SW'(STABLE_CYC - 1)) accept = 1'b1;
        end else if (mode_select == mode_active) begin
          // request withdrawn before qualifying: back to the old mode, no pulse
          state_nxt = RUN;
        end else begin
          cand_nxt = mode_select;
          stab_nxt = SW'(1);
        end
      end
      BLANK: begin
        blank_nxt = blank_cnt + BW'(1);
        if (blank_cnt == BW'(BLANK_CYC - 1)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (accept) begin
      mode_nxt = cand_nxt;
      if (BLANK_CYC > 0) begin
        blank_nxt = '0;
        state_nxt = BLANK;
      end else begin
        state_nxt = RUN;
      end
    end
  end

  // Out-of-range modes (0 or > NUM_MODES) find no slice and display as off.
  always_comb begin
    slice    = '0;
    in_range = 1'b0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode_active == MODE_W'(m + 1)) begin
        slice    = drv[m];
        in_range = 1'b1;
      end
    end
    led_nxt = '1;
    if (state != BLANK && in_range) led_nxt = ~slice;
`ifdef LED_MODE_MUX_MASK_EN
    led_nxt = led_nxt | ~led_mask;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      cand         <= '0;
      stab_cnt     <= '0;
      blank_cnt    <= '0;
      mode_active  <= '0;
      mode_changed <= 1'b0;
      busy         <= 1'b0;
      led_n        <= '1;
    end else begin
      state        <= state_nxt;
      cand         <= cand_nxt;
      stab_cnt     <= stab_nxt;
      blank_cnt    <= blank_nxt;
      mode_active  <= mode_nxt;
      mode_changed <= accept;
      busy         <= (state_nxt != RUN);
      led_n        <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_mode_mux.sv
// Scoreboard bench for led_mode_mux: stimulus queues cycle-stamped expectations,
// a negedge monitor compares led_n/mode_active/busy and every mode_changed pulse.
module tb_led_mode_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] drivers_signal;
  logic [3:0]  mode_select;
  logic [7:0]  led_n;
  logic [3:0]  mode_active;
  logic        busy;
  logic        mode_changed;
`ifdef LED_MODE_MUX_MASK_EN
  logic [7:0]  led_mask = 8'hFF;
`endif

  led_mode_mux #(.LED_W(8), .NUM_MODES(4), .MODE_W(4), .STABLE_CYC(4), .BLANK_CYC(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .drivers_signal (drivers_signal),
    .mode_select    (mode_select),
`ifdef LED_MODE_MUX_MASK_EN
    .led_mask       (led_mask),
`endif
    .led_n          (led_n),
    .mode_active    (mode_active),
    .busy           (busy),
    .mode_changed   (mode_changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic [3:0] mode;
    logic       busy;
    string      name;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [3:0] mode;
  } pulse_t;

  exp_t   exp_q[$];
  pulse_t pulse_q[$];
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input logic [7:0] led, input logic [3:0] mode,
                           input logic b, input string name);
    exp_t e;
    e.cyc = cyc + dly; e.led = led; e.mode = mode; e.busy = b; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic pulse_at(input int dly, input logic [3:0] mode);
    pulse_t p;
    p.cyc = cyc + dly; p.mode = mode;
    pulse_q.push_back(p);
  endtask

  // monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc || led_n !== e.led || mode_active !== e.mode || busy !== e.busy) begin
        failures++;
        $display("FAIL %s cyc=%0d: got led_n=%h mode_active=%0d busy=%b, want led_n=%h mode_active=%0d busy=%b (due cyc %0d)",
                 e.name, cyc, led_n, mode_active, busy, e.led, e.mode, e.busy, e.cyc);
      end
    end
    while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
      pulse_t p;
      p = pulse_q.pop_front();
      checks++; failures++;
      $display("FAIL missed_pulse: no mode_changed at cyc %0d, want pulse for mode %0d", p.cyc, p.mode);
    end
    if (mode_changed === 1'b1) begin
      checks++;
      if (pulse_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d: got mode_changed=1 mode_active=%0d, want no pulse", cyc, mode_active);
      end else begin
        pulse_t p;
        p = pulse_q.pop_front();
        if (p.cyc != cyc || mode_active !== p.mode) begin
          failures++;
          $display("FAIL pulse cyc=%0d mode=%0d, want cyc=%0d mode=%0d", cyc, mode_active, p.cyc, p.mode);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held 3 cycles with a pending request
    rst_n = 1'b0; mode_select = 4'd1; drivers_signal = 32'hFFFF_FFFF;
    expect_at(3, 8'hFF, 4'd0, 1'b0, "reset");
    tick(3);

    // first acceptance after release: 4 qualifying edges, pulse, 2 blank cycles
    rst_n = 1'b1;
    expect_at(1, 8'hFF, 4'd0, 1'b1, "rel_qual");
    pulse_at(4, 4'd1);
    expect_at(4, 8'hFF, 4'd1, 1'b1, "rel_accept");
    expect_at(6, 8'hFF, 4'd1, 1'b0, "rel_blank_end");
    expect_at(7, 8'h00, 4'd1, 1'b0, "rel_show");
    tick(7);

    // glitch to 2 for 3 cycles: no accept, old mode keeps displaying
    drivers_signal = {8'h3C, 8'hA5, 8'h0F, 8'h81};
    mode_select = 4'd2;
    expect_at(1, 8'h7E, 4'd1, 1'b1, "glitch_qual1");
    expect_at(3, 8'h7E, 4'd1, 1'b1, "glitch_qual3");
    tick(3);
    mode_select = 4'd1;
    expect_at(1, 8'h7E, 4'd1, 1'b0, "glitch_abandon");
    expect_at(2, 8'h7E, 4'd1, 1'b0, "glitch_hold");
    tick(2);

    // candidate restart: 2 for 2 cycles then 3 held
    mode_select = 4'd2;
    tick(2);
    mode_select = 4'd3;
    expect_at(1, 8'h7E, 4'd1, 1'b1, "restart_qual");
    pulse_at(4, 4'd3);
    expect_at(4, 8'h7E, 4'd3, 1'b1, "restart_accept");
    expect_at(5, 8'hFF, 4'd3, 1'b1, "restart_blank");
    expect_at(6, 8'hFF, 4'd3, 1'b0, "restart_blank_end");
    expect_at(7, 8'h5A, 4'd3, 1'b0, "restart_show_a5");
    tick(7);

    // one-cycle driver latency, then request off
    drivers_signal = {8'h3C, 8'hC3, 8'h0F, 8'h81};
    mode_select = 4'd0;
    expect_at(1, 8'h3C, 4'd3, 1'b1, "latency_c3");
    pulse_at(4, 4'd0);
    expect_at(4, 8'h3C, 4'd0, 1'b1, "off_accept");
    expect_at(7, 8'hFF, 4'd0, 1'b0, "off_show");
    tick(7);

    // out-of-range mode 7, and a request for 2 made during BLANK
    mode_select = 4'd7;
    pulse_at(4, 4'd7);
    expect_at(4, 8'hFF, 4'd7, 1'b1, "oor_accept");
    tick(4);
    mode_select = 4'd2;
    expect_at(2, 8'hFF, 4'd7, 1'b0, "oor_run_dark");
    expect_at(3, 8'hFF, 4'd7, 1'b1, "blank_ignore_qual");
    pulse_at(6, 4'd2);
    expect_at(6, 8'hFF, 4'd2, 1'b1, "mode2_accept");
    expect_at(9, 8'hF0, 4'd2, 1'b0, "mode2_show");
    tick(9);

    // reset in the middle of qualification
    mode_select = 4'd4;
    expect_at(1, 8'hF0, 4'd2, 1'b1, "midqual");
    tick(2);
    rst_n = 1'b0;
    expect_at(1, 8'hFF, 4'd0, 1'b0, "midqual_reset");
    tick(1);
    rst_n = 1'b1; mode_select = 4'd0;
    expect_at(2, 8'hFF, 4'd0, 1'b0, "after_reset_idle");
    tick(2);

`ifdef LED_MODE_MUX_MASK_EN
    drivers_signal = {8'h3C, 8'hC3, 8'h0F, 8'hFF};
    led_mask = 8'h0F;
    mode_select = 4'd1;
    pulse_at(4, 4'd1);
    expect_at(7, 8'hF0, 4'd1, 1'b0, "mask_0f");
    tick(7);
`endif

    tick(3);
    checks++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d checks and %0d pulses pending, want 0 and 0", exp_q.size(), pulse_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
